xpt_itable_sequencer: RTL and testbench
=======================================

Name: xpt_itable_sequencer

Overview:
- Upstream end of the instruction decoder interface: generates and holds the phase timer XPT/notXPT and the instruction byte ITABLE/notITABLE that the decoder tree consumes.
- Consumes the decoder's control pulses, which reset phase, select machine cycle, and clear or hold the opcode.
- Runs the machine-cycle state machine (M1 fetch, R operand read, A auxiliary) and the memory read handshake for opcode and operand bytes.

Parameters:
- XPT_W, 4, phase timer width; wraps modulo 2^XPT_W.
- OPCODE_RESET, 8'h00, value loaded into ITABLE on reset and on P2_Reset_ITABLE.
- WD_LIMIT, 255, watchdog cycle limit; used only with SEQ_WATCHDOG_EN.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- Dt_in  in  8  memory read data.
- mem_ack  in  1  memory read complete; Dt_in valid in the same cycle.
- PR_Reset_XPT  in  1  decoder pulse: XPT <= 0.
- P2_Set_CM1  in  1  decoder pulse: next cycle = M1.
- P2_Set_CMR  in  1  decoder pulse: next cycle = R.
- P2_Set_CMA  in  1  decoder pulse: next cycle = A.
- P2_Reset_ITABLE  in  1  decoder pulse: ITABLE <= OPCODE_RESET.
- Pa_Ophd  in  1  opcode hold: copy OP into OPold.
- XPT  out  XPT_W  phase timer.
- notXPT  out  XPT_W  bitwise inverse of XPT, registered.
- ITABLE  out  8  current instruction byte.
- notITABLE  out  8  bitwise inverse of ITABLE, registered.
- dec_enable  out  1  enable for the decoder tree.
- CM1, CMR, CMA  out  1 each  one-hot machine-cycle state.
- mem_req  out  1  memory read request.
- OP  out  8  last operand byte.
- OPold  out  8  previous operand byte.
- wd_err  out  1  watchdog error flag; held 0 without SEQ_WATCHDOG_EN.

Behaviour:
- Reset values:
  - XPT=0, notXPT=all ones.
  - ITABLE=OPCODE_RESET, notITABLE=~OPCODE_RESET.
  - CM1=1, CMR=0, CMA=0.
  - mem_req=0, dec_enable=0, OP=0, OPold=0, wd_err=0.
- Reset mid-transaction drops mem_req next cycle. A mem_ack that arrives in the reset cycle is ignored.
- Inverted outputs are registered together with their true outputs. The invariant notX==~X holds every cycle.
- CM1 (opcode fetch):
  - XPT=0: mem_req=1.
  - XPT=1: stall (XPT holds, mem_req held 1) until mem_ack. On mem_ack: ITABLE<=Dt_in, mem_req<=0, XPT<=2.
  - XPT>=2: dec_enable=1, XPT increments each cycle.
- CMR (operand read):
  - XPT=0: mem_req=1.
  - XPT=1: stall until mem_ack. On mem_ack: OP<=Dt_in, XPT<=2.
  - ITABLE is unchanged throughout.
  - dec_enable=1 at all XPT.
- CMA: no memory access. dec_enable=1, XPT free-runs.
- Decoder pulses are sampled each cycle only while dec_enable=1 and are ignored otherwise. They take effect at the next edge.
- Cycle-select priority when several are set: P2_Set_CM1 > P2_Set_CMR > P2_Set_CMA. Exactly one state stays set.
- PR_Reset_XPT overrides increment and stall. XPT goes to 0 next cycle.
- Any cycle-select pulse without PR_Reset_XPT still changes state; XPT continues counting.
- P2_Reset_ITABLE together with a mem_ack capture: the reset wins, ITABLE=OPCODE_RESET.
- Pa_Ophd: OPold<=OP. If Pa_Ophd coincides with an OP capture, OPold takes the old OP and OP takes Dt_in.
- XPT wraps from 2^XPT_W-1 to 0 when no reset pulse arrives. This is not an error.
- mem_ack while mem_req=0 is ignored.
- mem_req changes only on clock edges. A request once raised stays high until mem_ack or reset.

Optional Feature:
- Macro SEQ_WATCHDOG_EN.
- Enabled:
  - An 8-bit counter counts consecutive stall cycles (XPT=1 with mem_req=1 and no mem_ack).
  - When the count reaches WD_LIMIT: wd_err<=1 (sticky until reset), mem_req<=0, state<=CM1, XPT<=0, ITABLE<=OPCODE_RESET.
  - The counter clears on mem_ack or on any XPT change.
- Disabled: no counter exists, wd_err is tied 0, and stalls are unbounded.

Test Plan:
- Reset then run: CM1=1, XPT=0, mem_req rises at XPT=0. With mem_ack at cycle 3, Dt_in=8'h01: ITABLE=8'h01, notITABLE=8'hFE, XPT=2, dec_enable=1.
- Stall: hold mem_ack low 10 cycles → XPT stays 1 and mem_req stays 1 throughout; release → capture, XPT=2.
- Fetch 8'h02, then pulse P2_Set_CMR + PR_Reset_XPT at XPT=3:
  - next cycle CMR=1, XPT=0.
  - operand 8'hA5 on ack → OP=8'hA5, ITABLE still 8'h02.
  - then Pa_Ophd → OPold=8'hA5.
- Assert P2_Set_CM1, P2_Set_CMA and P2_Reset_ITABLE in the same cycle → CM1=1, CMA=0, ITABLE=8'h00. Assert the same pulses while dec_enable=0 → no effect.
- In CMA with no pulses for 16 cycles → XPT wraps 15→0, wd_err=0.
- With SEQ_WATCHDOG_EN and WD_LIMIT=255, hold mem_ack=0 → after 255 stall cycles wd_err=1, mem_req=0, CM1=1, XPT=0. Without the macro, wd_err stays 0 and the stall persists.

Source files
------------

// File: rtl/xpt_itable_sequencer.sv
// Phase timer / instruction byte sequencer feeding the decoder tree; all outputs registered, 1-cycle pulse response.
// Stalls at XPT=1 until mem_ack; optional stall watchdog built with `define SEQ_WATCHDOG_EN.
module xpt_itable_sequencer #(
  parameter int         XPT_W        = 4,
  parameter logic [7:0] OPCODE_RESET = 8'h00,
  parameter int         WD_LIMIT     = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       Dt_in,
  input  logic             mem_ack,
  input  logic             PR_Reset_XPT,
  input  logic             P2_Set_CM1,
  input  logic             P2_Set_CMR,
  input  logic             P2_Set_CMA,
  input  logic             P2_Reset_ITABLE,
  input  logic             Pa_Ophd,
  output logic [XPT_W-1:0] XPT,
  output logic [XPT_W-1:0] notXPT,
  output logic [7:0]       ITABLE,
  output logic [7:0]       notITABLE,
  output logic             dec_enable,
  output logic             CM1,
  output logic             CMR,
  output logic             CMA,
  output logic             mem_req,
  output logic [7:0]       OP,
  output logic [7:0]       OPold,
  output logic             wd_err
);

  localparam logic [2:0] ST_M1 = 3'b001;
  localparam logic [2:0] ST_R  = 3'b010;
  localparam logic [2:0] ST_A  = 3'b100;

  localparam logic [XPT_W-1:0] XPT_ZERO = '0;
  localparam logic [XPT_W-1:0] XPT_ONE  = XPT_W'(1);
  localparam logic [XPT_W-1:0] XPT_TWO  = XPT_W'(2);

  logic [XPT_W-1:0] xpt_q, xpt_d, notxpt_q;
  logic [7:0]       itable_q, itable_d, notitable_q;
  logic [2:0]       state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic [7:0]       op_q, op_d, opold_q, opold_d;

  logic dec_en;
  logic in_mem;
  logic at_req;
  logic at_wait;
  logic ack_ok;
  logic capture;
  logic stall;
  logic xpt_rst;
  logic wd_trip;

  // Decode of the current registered state; pulses are honoured only when dec_en is high.
  always_comb begin
    in_mem  = state_q[0] | state_q[1];
    dec_en  = state_q[0] ? (xpt_q >= XPT_TWO) : 1'b1;
    at_req  = in_mem && (xpt_q == XPT_ZERO);
    at_wait = in_mem && (xpt_q == XPT_ONE);
    ack_ok  = mem_req_q && mem_ack;
    capture = at_wait && ack_ok;
    stall   = at_wait && !ack_ok;
    xpt_rst = dec_en && PR_Reset_XPT;
  end

`ifdef SEQ_WATCHDOG_EN
  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       wd_err_q, wd_err_d;
  logic       wd_stall;

  // Any cycle in which XPT moves or the ack lands restarts the count.
  always_comb begin
    wd_stall = stall && mem_req_q && !xpt_rst;
    wd_trip  = wd_stall && (wd_cnt_q == 8'(WD_LIMIT - 1));
    wd_cnt_d = 8'd0;
    if (wd_stall && !wd_trip) begin
      wd_cnt_d = wd_cnt_q + 8'd1;
    end
    wd_err_d = wd_err_q | wd_trip;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q <= 8'd0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  assign wd_err = wd_err_q;
`else
  logic unused_wd_cfg;

  assign unused_wd_cfg = (WD_LIMIT != 0);
  assign wd_trip       = 1'b0;
  assign wd_err        = 1'b0;
`endif

  always_comb begin
    xpt_d = xpt_q + XPT_ONE;
    if (wd_trip || xpt_rst) begin
      xpt_d = XPT_ZERO;
    end else if (capture) begin
      xpt_d = XPT_TWO;
    end else if (stall) begin
      xpt_d = xpt_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (wd_trip) begin
      state_d = ST_M1;
    end else if (dec_en) begin
      if (P2_Set_CM1) begin
        state_d = ST_M1;
      end else if (P2_Set_CMR) begin
        state_d = ST_R;
      end else if (P2_Set_CMA) begin
        state_d = ST_A;
      end
    end
  end

  // A raised request is only withdrawn by its ack, a watchdog trip, or reset.
  always_comb begin
    mem_req_d = mem_req_q;
    if (wd_trip || ack_ok) begin
      mem_req_d = 1'b0;
    end else if (at_req || at_wait) begin
      mem_req_d = 1'b1;
    end
  end

  always_comb begin
    itable_d = itable_q;
    if (wd_trip || (dec_en && P2_Reset_ITABLE)) begin
      itable_d = OPCODE_RESET;
    end else if (capture && state_q[0]) begin
      itable_d = Dt_in;
    end
  end

  always_comb begin
    op_d    = op_q;
    opold_d = opold_q;
    if (capture && state_q[1]) begin
      op_d = Dt_in;
    end
    if (dec_en && Pa_Ophd) begin
      opold_d = op_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xpt_q       <= XPT_ZERO;
      notxpt_q    <= ~XPT_ZERO;
      itable_q    <= OPCODE_RESET;
      notitable_q <= ~OPCODE_RESET;
      state_q     <= ST_M1;
      mem_req_q   <= 1'b0;
      op_q        <= 8'h00;
      opold_q     <= 8'h00;
    end else begin
      xpt_q       <= xpt_d;
      notxpt_q    <= ~xpt_d;
      itable_q    <= itable_d;
      notitable_q <= ~itable_d;
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      op_q        <= op_d;
      opold_q     <= opold_d;
    end
  end

  assign XPT        = xpt_q;
  assign notXPT     = notxpt_q;
  assign ITABLE     = itable_q;
  assign notITABLE  = notitable_q;
  assign dec_enable = dec_en;
  assign CM1        = state_q[0];
  assign CMR        = state_q[1];
  assign CMA        = state_q[2];
  assign mem_req    = mem_req_q;
  assign OP         = op_q;
  assign OPold      = opold_q;

endmodule

// File: tb/tb_xpt_itable_sequencer.sv
// Directed bench for xpt_itable_sequencer: fetch, stall, operand read, pulse priority, wrap, reset and watchdog.
module tb_xpt_itable_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Dt_in;
  logic       mem_ack;
  logic       PR_Reset_XPT, P2_Set_CM1, P2_Set_CMR, P2_Set_CMA, P2_Reset_ITABLE, Pa_Ophd;
  logic [3:0] XPT, notXPT;
  logic [7:0] ITABLE, notITABLE, OP, OPold;
  logic       dec_enable, CM1, CMR, CMA, mem_req, wd_err;

  int total = 0;
  int bad   = 0;

  xpt_itable_sequencer dut (
    .clk(clk), .reset(reset), .Dt_in(Dt_in), .mem_ack(mem_ack),
    .PR_Reset_XPT(PR_Reset_XPT), .P2_Set_CM1(P2_Set_CM1), .P2_Set_CMR(P2_Set_CMR),
    .P2_Set_CMA(P2_Set_CMA), .P2_Reset_ITABLE(P2_Reset_ITABLE), .Pa_Ophd(Pa_Ophd),
    .XPT(XPT), .notXPT(notXPT), .ITABLE(ITABLE), .notITABLE(notITABLE),
    .dec_enable(dec_enable), .CM1(CM1), .CMR(CMR), .CMA(CMA), .mem_req(mem_req),
    .OP(OP), .OPold(OPold), .wd_err(wd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    PR_Reset_XPT = 0; P2_Set_CM1 = 0; P2_Set_CMR = 0; P2_Set_CMA = 0;
    P2_Reset_ITABLE = 0; Pa_Ophd = 0; mem_ack = 0;
  endtask

  initial begin
    clr();
    Dt_in = 8'h00;
    reset = 1;
    tick(); tick();
    chk("rst_xpt", XPT, 0);
    chk("rst_notxpt", notXPT, 4'hF);
    chk("rst_itable", ITABLE, 8'h00);
    chk("rst_notitable", notITABLE, 8'hFF);
    chk("rst_cm1", CM1, 1);
    chk("rst_cmr", CMR, 0);
    chk("rst_cma", CMA, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_dec", dec_enable, 0);
    chk("rst_op", OP, 0);
    chk("rst_opold", OPold, 0);
    chk("rst_wd", wd_err, 0);

    // First fetch
    reset = 0;
    tick();
    chk("f1_xpt", XPT, 1);
    chk("f1_req", mem_req, 1);
    chk("f1_dec", dec_enable, 0);
    tick();
    chk("f1_wait_xpt", XPT, 1);
    mem_ack = 1; Dt_in = 8'h01;
    tick(); clr();
    chk("f1_itable", ITABLE, 8'h01);
    chk("f1_notitable", notITABLE, 8'hFE);
    chk("f1_xpt2", XPT, 2);
    chk("f1_dec2", dec_enable, 1);
    chk("f1_req_drop", mem_req, 0);

    // Restart fetch and stall ten cycles; pulses during the stall must be ignored
    P2_Set_CM1 = 1; PR_Reset_XPT = 1;
    tick(); clr();
    chk("f2_xpt0", XPT, 0);
    chk("f2_cm1", CM1, 1);
    tick();
    chk("f2_xpt1", XPT, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        P2_Set_CMA = 1; P2_Reset_ITABLE = 1; PR_Reset_XPT = 1;
      end
      tick(); clr();
      chk("stall_xpt", XPT, 1);
      chk("stall_req", mem_req, 1);
      if (i == 5) begin
        chk("ign_cm1", CM1, 1);
        chk("ign_cma", CMA, 0);
        chk("ign_itable", ITABLE, 8'h01);
      end
    end
    mem_ack = 1; Dt_in = 8'h02;
    tick(); clr();
    chk("f2_itable", ITABLE, 8'h02);
    chk("f2_xpt2", XPT, 2);
    tick();
    chk("f2_xpt3", XPT, 3);

    // Operand read
    P2_Set_CMR = 1; PR_Reset_XPT = 1;
    tick(); clr();
    chk("r_cmr", CMR, 1);
    chk("r_cm1", CM1, 0);
    chk("r_xpt0", XPT, 0);
    chk("r_dec", dec_enable, 1);
    tick();
    chk("r_xpt1", XPT, 1);
    chk("r_req", mem_req, 1);
    mem_ack = 1; Dt_in = 8'hA5;
    tick(); clr();
    chk("r_op", OP, 8'hA5);
    chk("r_itable", ITABLE, 8'h02);
    chk("r_xpt2", XPT, 2);
    Pa_Ophd = 1;
    tick(); clr();
    chk("r_opold", OPold, 8'hA5);
    chk("r_xpt3", XPT, 3);

    // Cycle-select priority with ITABLE reset
    P2_Set_CM1 = 1; P2_Set_CMA = 1; P2_Reset_ITABLE = 1;
    tick(); clr();
    chk("pri_cm1", CM1, 1);
    chk("pri_cma", CMA, 0);
    chk("pri_cmr", CMR, 0);
    chk("pri_itable", ITABLE, 8'h00);
    chk("pri_notitable", notITABLE, 8'hFF);
    chk("pri_xpt", XPT, 4);

    // CMA free-run and wrap
    P2_Set_CMA = 1; PR_Reset_XPT = 1;
    tick(); clr();
    chk("a_cma", CMA, 1);
    chk("a_xpt0", XPT, 0);
    repeat (15) tick();
    chk("a_xpt15", XPT, 15);
    chk("a_notxpt15", notXPT, 0);
    tick();
    chk("a_wrap", XPT, 0);
    chk("a_wd", wd_err, 0);
    chk("a_still_cma", CMA, 1);
    chk("a_req", mem_req, 0);

    // OP capture coincident with opcode hold
    P2_Set_CMR = 1; PR_Reset_XPT = 1;
    tick(); clr();
    tick();
    chk("c_req", mem_req, 1);
    mem_ack = 1; Dt_in = 8'h5A; Pa_Ophd = 1;
    tick(); clr();
    chk("c_op", OP, 8'h5A);
    chk("c_opold", OPold, 8'hA5);
    // Stray ack with no request outstanding
    mem_ack = 1; Dt_in = 8'hFF;
    tick(); clr();
    chk("stray_op", OP, 8'h5A);
    chk("stray_req", mem_req, 0);

    // Reset mid-request with ack in the reset cycle
    P2_Set_CM1 = 1; PR_Reset_XPT = 1;
    tick(); clr();
    tick();
    chk("mr_req", mem_req, 1);
    reset = 1; mem_ack = 1; Dt_in = 8'h77;
    tick(); clr();
    chk("mr_req_drop", mem_req, 0);
    chk("mr_itable", ITABLE, 8'h00);
    chk("mr_xpt", XPT, 0);
    reset = 0;
    tick();
    chk("wd_start_xpt", XPT, 1);
    chk("wd_start_req", mem_req, 1);

`ifdef SEQ_WATCHDOG_EN
    repeat (254) tick();
    chk("wd_pre", wd_err, 0);
    chk("wd_pre_xpt", XPT, 1);
    tick();
    chk("wd_err", wd_err, 1);
    chk("wd_req", mem_req, 0);
    chk("wd_cm1", CM1, 1);
    chk("wd_xpt", XPT, 0);
`else
    repeat (300) tick();
    chk("nowd_err", wd_err, 0);
    chk("nowd_xpt", XPT, 1);
    chk("nowd_req", mem_req, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
